// File: rtl/button_counter.sv
// Up/down 4-bit counter driven by two debounced push-buttons, with a
// synchronous load and one-cycle step/wrap pulses.

module button_counter_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_level;
    logic          w_done;

    assign w_level = r_sync2;
    assign w_done  = (r_cnt == LAST);

    // Event is decoded from registered state so the count moves on the same
    // edge the FSM accepts the press; nothing here depends on i_btn directly.
    assign o_press = (r_state == PRESS_WAIT) && w_level && w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= RELEASED;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            unique case (r_state)
                RELEASED: begin
                    if (w_level) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_level) begin
                        r_state <= RELEASED;
                    end else if (w_done) begin
                        r_state <= PRESSED;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!w_level) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_level) begin
                        r_state <= PRESSED;
                    end else if (w_done) begin
                        r_state <= RELEASED;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

module button_counter #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       step,
    output logic       wrap
);

    logic       w_up_ev;
    logic       w_dn_ev;
    logic [3:0] r_count;
    logic       r_step;
    logic       r_wrap;

    button_counter_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_up),
        .o_press(w_up_ev)
    );

    button_counter_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_dn (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_down),
        .o_press(w_dn_ev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_up_ev && w_dn_ev) begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_up_ev) begin
            r_count <= r_count + 4'd1;
            r_step  <= 1'b1;
            r_wrap  <= (r_count == 4'd15);
        end else if (w_dn_ev) begin
            r_count <= r_count - 4'd1;
            r_step  <= 1'b1;
            r_wrap  <= (r_count == 4'd0);
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign {A, B, C, D} = r_count;
    assign step = r_step;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: load table, directed button sequences and
// random traffic, all compared against a run-length debounce model.

module tb_button_counter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       load;
    logic [3:0] load_val;
    logic       A, B, C, D;
    logic       step, wrap;

    always #5 clk = ~clk;

    button_counter #(.DEBOUNCE_CYCLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .load    (load),
        .load_val(load_val),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .step    (step),
        .wrap    (wrap)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: a button is accepted once its synchronized level has differed
    // from the accepted level for N+1 consecutive samples.
    logic [1:0] sh_u, sh_d;
    logic       acc_u, acc_d;
    int         run_u, run_d;
    logic [3:0] m_cnt;
    logic       m_step, m_wrap;

    task automatic deb(input logic lvl, inout logic acc, inout int run,
                       output logic ev);
        ev = 1'b0;
        if (lvl != acc) begin
            run++;
            if (run == N + 1) begin
                acc = lvl;
                run = 0;
                ev  = lvl;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_step();
        logic lu, ld, eu, ed;
        if (rst) begin
            sh_u = 2'b00; sh_d = 2'b00;
            acc_u = 1'b0; acc_d = 1'b0;
            run_u = 0; run_d = 0;
            m_cnt = 4'd0; m_step = 1'b0; m_wrap = 1'b0;
        end else begin
            lu = sh_u[1]; sh_u = {sh_u[0], btn_up};
            ld = sh_d[1]; sh_d = {sh_d[0], btn_down};
            deb(lu, acc_u, run_u, eu);
            deb(ld, acc_d, run_d, ed);
            m_step = 1'b0;
            m_wrap = 1'b0;
            if (load) begin
                m_cnt = load_val;
            end else if (eu && ed) begin
                m_step = 1'b0;
            end else if (eu) begin
                m_wrap = (m_cnt == 4'd15);
                m_cnt  = (m_cnt + 4'd1) % 16;
                m_step = 1'b1;
            end else if (ed) begin
                m_wrap = (m_cnt == 4'd0);
                m_cnt  = (m_cnt + 4'd15) % 16;
                m_step = 1'b1;
            end
        end
    endtask

    function automatic logic [3:0] cnt();
        return {A, B, C, D};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if ({A, B, C, D, step, wrap} !== {m_cnt, m_step, m_wrap}) begin
            errors++;
            $display("FAIL model cyc=%0d got cnt=%0d step=%b wrap=%b exp cnt=%0d step=%b wrap=%b",
                     cyc, cnt(), step, wrap, m_cnt, m_step, m_wrap);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic wait_change(input int maxc, output int edges);
        logic [3:0] c0;
        c0 = cnt();
        edges = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (cnt() !== c0) begin
                edges = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] lv;
        logic [3:0] exp_cnt;
        logic       exp_step;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         e;
        int         seen;
        logic [3:0] c0;
        logic [3:0] tmp;
        int         hu, hd;

        vecs[0] = '{1'b0, 1'b1, 4'd3,  4'd3,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 4'd7,  4'd3,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 4'd5,  4'd0,  1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 4'd10, 4'd10, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 4'd2,  4'd10, 1'b0, 1'b0};

        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        load = 1'b0; load_val = 4'd0;
        idle(3);
        check("reset_cnt", int'(cnt()), 0);
        check("reset_step", int'(step), 0);
        check("reset_wrap", int'(wrap), 0);
        rst = 1'b0;
        idle(2);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; load = vecs[i].load; load_val = vecs[i].lv;
            tick();
            check($sformatf("vec%0d_cnt", i), int'(cnt()), int'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_step", i), int'(step), int'(vecs[i].exp_step));
            check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
        end
        rst = 1'b1; load = 1'b0;
        tick();
        rst = 1'b0;
        idle(2);

        // Clean press held 20 cycles.
        btn_up = 1'b1;
        wait_change(20, e);
        check("clean_latency", e, 7);
        check("clean_cnt", int'(cnt()), 1);
        check("clean_step", int'(step), 1);
        check("clean_wrap", int'(wrap), 0);
        idle(13);
        check("clean_hold_cnt", int'(cnt()), 1);
        btn_up = 1'b0;
        idle(12);

        // Bouncing input, then a stable rise.
        c0 = cnt();
        for (int j = 0; j < 15; j++) begin
            btn_up = j[0];
            idle(2);
        end
        check("bounce_nochange", int'(cnt()), int'(c0));
        btn_up = 1'b1;
        wait_change(20, e);
        check("bounce_latency", e, 7);
        tmp = c0 + 4'd1;
        idle(15);
        check("bounce_once", int'(cnt()), int'(tmp));
        btn_up = 1'b0;
        idle(12);

        // Wrap both ways.
        load = 1'b1; load_val = 4'd15;
        tick();
        load = 1'b0;
        check("load15", int'(cnt()), 15);
        btn_up = 1'b1;
        wait_change(20, e);
        check("wrap_up_cnt", int'(cnt()), 0);
        check("wrap_up_step", int'(step), 1);
        check("wrap_up_wrap", int'(wrap), 1);
        idle(3);
        btn_up = 1'b0;
        idle(12);
        btn_down = 1'b1;
        wait_change(20, e);
        check("wrap_dn_cnt", int'(cnt()), 15);
        check("wrap_dn_step", int'(step), 1);
        check("wrap_dn_wrap", int'(wrap), 1);
        idle(3);
        btn_down = 1'b0;
        idle(12);

        // Simultaneous presses cancel; a lone re-press of down counts.
        c0 = cnt();
        seen = 0;
        btn_up = 1'b1; btn_down = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step) seen++;
        end
        check("both_cnt", int'(cnt()), int'(c0));
        check("both_steps", seen, 0);
        btn_down = 1'b0;
        idle(12);
        btn_down = 1'b1;
        wait_change(20, e);
        tmp = c0 - 4'd1;
        check("redown_latency", e, 7);
        check("redown_cnt", int'(cnt()), int'(tmp));
        check("redown_step", int'(step), 1);
        btn_up = 1'b0; btn_down = 1'b0;
        idle(12);

        // Reset during PRESS_WAIT with the button held through it.
        btn_up = 1'b1;
        idle(4);
        rst = 1'b1;
        idle(2);
        check("rst_held_cnt", int'(cnt()), 0);
        rst = 1'b0;
        wait_change(20, e);
        check("rst_held_latency", e, 7);
        check("rst_held_cnt1", int'(cnt()), 1);
        btn_up = 1'b0;
        idle(12);

        // Load on the same edge as a completed press.
        btn_up = 1'b1;
        idle(6);
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        check("load_press_cnt", int'(cnt()), 9);
        check("load_press_step", int'(step), 0);
        check("load_press_wrap", int'(wrap), 0);
        idle(5);
        check("load_press_hold", int'(cnt()), 9);
        btn_up = 1'b0;
        idle(12);

        // Random traffic against the model.
        hu = 0; hd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hu <= 0) begin
                btn_up = 1'($urandom_range(0, 1));
                hu = $urandom_range(1, 12);
            end
            if (hd <= 0) begin
                btn_down = 1'($urandom_range(0, 1));
                hd = $urandom_range(1, 12);
            end
            hu--; hd--;
            load = ($urandom_range(0, 19) == 0);
            load_val = 4'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
